// File: rtl/perfmon_pkg.sv
// Shared register map, CTRL bit positions and counter config layout for the perfmon event counter bank.
// Pure definitions; no timing or flow-control behaviour.
package perfmon_pkg;

    localparam logic [6:0] CTRL_ADDR  = 7'h00;
    localparam logic [6:0] OVF_ADDR   = 7'h04;
    localparam logic [6:0] IMASK_ADDR = 7'h08;

    // Offsets inside each counter's 16-byte window, which starts at 0x10 * (i + 1)
    localparam logic [3:0] CFG_OFS = 4'h0;
    localparam logic [3:0] LO_OFS  = 4'h4;
    localparam logic [3:0] HI_OFS  = 4'h8;

    localparam int CTRL_GLOBAL_EN = 0;
    localparam int CTRL_FREEZE    = 1;
    localparam int CTRL_CLEAR_ALL = 2;
    localparam int CFG_EN_BIT     = 8;

    typedef struct packed {
        logic       cnt_en;
        logic [4:0] event_sel;
    } cfg_t;

endpackage

// File: rtl/perfmon_counter_slice.sv
// One counter: config, CNT_WIDTH counter with preload/wrap, HI shadow captured on LO reads.
// Increment and overflow flag take effect on the same edge; no backpressure, writes always accepted.
module perfmon_counter_slice
    import perfmon_pkg::*;
#(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 48
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  clear_all,
    input  logic                  count_en,
    input  logic                  cfg_we,
    input  logic                  lo_we,
    input  logic                  hi_we,
    input  logic                  lo_rd,
    input  logic [31:0]           wdat,
    input  logic [NUM_EVENTS-1:0] events,
    output logic [31:0]           cfg_rdat,
    output logic [31:0]           cnt_lo,
    output logic [CNT_WIDTH-33:0] hi_shadow,
    output logic                  ovf_set
);

    localparam int HW = CNT_WIDTH - 32;

    cfg_t                 cfg_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [HW-1:0]        shadow_q;
    logic [31:0]          ev_ext;
    logic                 sel_ok;
    logic                 inc;

    assign ev_ext  = 32'(events);
    assign sel_ok  = {27'b0, cfg_q.event_sel} < 32'(NUM_EVENTS);
    assign inc     = count_en & cfg_q.cnt_en & sel_ok & ev_ext[cfg_q.event_sel];
    // A preload or clear on the wrap edge wins, so no overflow is reported then
    assign ovf_set = inc & ~clear_all & ~lo_we & ~hi_we & (&cnt_q);

    assign cfg_rdat  = sel_ok ? {23'b0, cfg_q.cnt_en, 3'b0, cfg_q.event_sel}
                              : {23'b0, cfg_q.cnt_en, 8'b0};
    assign cnt_lo    = cnt_q[31:0];
    assign hi_shadow = shadow_q;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (cfg_we) begin
            cfg_q.cnt_en    <= wdat[CFG_EN_BIT];
            cfg_q.event_sel <= wdat[4:0];
        end
    end

    // Low-half preload never carries into the high half
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_all) begin
            cnt_q <= '0;
        end else if (lo_we) begin
            cnt_q[31:0] <= wdat;
        end else if (hi_we) begin
            cnt_q[CNT_WIDTH-1:32] <= wdat[HW-1:0];
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (clear_all) begin
            shadow_q <= '0;
        end else if (lo_rd) begin
            shadow_q <= cnt_q[CNT_WIDTH-1:32];
        end
    end

endmodule

// File: rtl/perfmon_event_counters.sv
// MMIO perfmon bank: NUM_CNTRS event counters with sticky OVF, maskable irq, freeze-on-overflow.
// Reads are combinational, perf_irq lags OVF by one cycle; no backpressure, every access completes in one cycle.
module perfmon_event_counters
    import perfmon_pkg::*;
#(
    parameter int NUM_CNTRS  = 4,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 48
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic                  wr_en,
    input  logic [6:0]            addr_bus,
    input  logic [31:0]           data_store,
    output logic [31:0]           data_fetch,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  perf_irq
);

    localparam int HW = CNT_WIDTH - 32;

    logic                 global_en_q;
    logic                 freeze_q;
    logic [NUM_CNTRS-1:0] ovf_q;
    logic [NUM_CNTRS-1:0] imask_q;
    logic [NUM_CNTRS-1:0] ovf_set;
    logic [NUM_CNTRS-1:0] w1c_mask;

    logic                 bus_wr;
    logic                 bus_rd;
    logic                 ctrl_wr;
    logic                 clear_all;
    logic                 count_en;

    logic [31:0]          cfg_rdat  [NUM_CNTRS];
    logic [31:0]          cnt_lo    [NUM_CNTRS];
    logic [HW-1:0]        hi_shadow [NUM_CNTRS];

    assign bus_wr    = sel & wr_en;
    assign bus_rd    = sel & ~wr_en;
    assign ctrl_wr   = bus_wr & (addr_bus == CTRL_ADDR);
    assign clear_all = ctrl_wr & data_store[CTRL_CLEAR_ALL];
    assign w1c_mask  = (bus_wr && addr_bus == OVF_ADDR) ? data_store[NUM_CNTRS-1:0] : '0;
    // Freeze stops every counter while any overflow is pending
    assign count_en  = global_en_q & ~(freeze_q & (|ovf_q));

    for (genvar i = 0; i < NUM_CNTRS; i++) begin : g_slice
        logic slot_hit;
        assign slot_hit = addr_bus[6:4] == 3'(i + 1);

        perfmon_counter_slice #(
            .NUM_EVENTS (NUM_EVENTS),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_slice (
            .core_clk  (core_clk),
            .rst_n     (rst_n),
            .clear_all (clear_all),
            .count_en  (count_en),
            .cfg_we    (bus_wr & slot_hit & (addr_bus[3:0] == CFG_OFS)),
            .lo_we     (bus_wr & slot_hit & (addr_bus[3:0] == LO_OFS)),
            .hi_we     (bus_wr & slot_hit & (addr_bus[3:0] == HI_OFS)),
            .lo_rd     (bus_rd & slot_hit & (addr_bus[3:0] == LO_OFS)),
            .wdat      (data_store),
            .events    (events),
            .cfg_rdat  (cfg_rdat[i]),
            .cnt_lo    (cnt_lo[i]),
            .hi_shadow (hi_shadow[i]),
            .ovf_set   (ovf_set[i])
        );
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            global_en_q <= 1'b0;
            freeze_q    <= 1'b0;
            imask_q     <= '0;
        end else begin
            if (ctrl_wr) begin
                global_en_q <= data_store[CTRL_GLOBAL_EN];
                freeze_q    <= data_store[CTRL_FREEZE];
            end
            if (bus_wr && addr_bus == IMASK_ADDR) begin
                imask_q <= data_store[NUM_CNTRS-1:0];
            end
        end
    end

    // A hardware set on the same edge as its W1C keeps the bit set
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q    <= '0;
            perf_irq <= 1'b0;
        end else begin
            ovf_q    <= clear_all ? '0 : ((ovf_q & ~w1c_mask) | ovf_set);
            perf_irq <= |(ovf_q & imask_q);
        end
    end

    always_comb begin
        data_fetch = '0;
        if (bus_rd) begin
            if (addr_bus == CTRL_ADDR) begin
                data_fetch = {30'b0, freeze_q, global_en_q};
            end else if (addr_bus == OVF_ADDR) begin
                data_fetch = 32'(ovf_q);
            end else if (addr_bus == IMASK_ADDR) begin
                data_fetch = 32'(imask_q);
            end
            for (int i = 0; i < NUM_CNTRS; i++) begin
                if (addr_bus[6:4] == 3'(i + 1)) begin
                    case (addr_bus[3:0])
                        CFG_OFS: data_fetch = cfg_rdat[i];
                        LO_OFS:  data_fetch = cnt_lo[i];
                        HI_OFS:  data_fetch = 32'(hi_shadow[i]);
                        default: data_fetch = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_perfmon_event_counters.sv
// Self-checking bench for perfmon_event_counters: expected read data is queued as each read is
// issued and popped when the combinational read data is sampled.
module tb_perfmon_event_counters;

    localparam int NC = 4;
    localparam int NE = 8;
    localparam int CW = 48;

    logic          core_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          sel      = 1'b0;
    logic          wr_en    = 1'b0;
    logic [6:0]    addr_bus = '0;
    logic [31:0]   data_store = '0;
    logic [31:0]   data_fetch;
    logic [NE-1:0] events   = '0;
    logic          perf_irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    perfmon_event_counters #(
        .NUM_CNTRS  (NC),
        .NUM_EVENTS (NE),
        .CNT_WIDTH  (CW)
    ) dut (
        .core_clk   (core_clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .wr_en      (wr_en),
        .addr_bus   (addr_bus),
        .data_store (data_store),
        .data_fetch (data_fetch),
        .events     (events),
        .perf_irq   (perf_irq)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [NE-1:0] ev);
        @(negedge core_clk);
        sel = 1'b1; wr_en = 1'b1; addr_bus = a; data_store = d; events = ev;
        #1;
        check("fetch_zero_on_write", data_fetch, 32'h0);
        @(posedge core_clk);
        #1;
        sel = 1'b0; wr_en = 1'b0; data_store = '0; events = '0;
    endtask

    task automatic rd(input logic [6:0] a, input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge core_clk);
        sel = 1'b1; wr_en = 1'b0; addr_bus = a;
        #1;
        check(tag_q.pop_front(), data_fetch, exp_q.pop_front());
        @(posedge core_clk);
        #1;
        sel = 1'b0;
    endtask

    task automatic pulse(input logic [NE-1:0] ev, input int cycles);
        @(negedge core_clk);
        events = ev;
        repeat (cycles) @(posedge core_clk);
        #1;
        events = '0;
    endtask

    initial begin
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        rst_n = 1'b1;

        // Reset state
        check("irq_reset", 32'(perf_irq), 32'h0);
        rd(7'h00, "ctrl_reset", 32'h0);
        rd(7'h04, "ovf_reset", 32'h0);
        rd(7'h08, "imask_reset", 32'h0);
        for (int i = 0; i < NC; i++) begin
            rd(7'(8'h10 + 8'(16 * i)), "cfg_reset", 32'h0);
            rd(7'(8'h14 + 8'(16 * i)), "lo_reset", 32'h0);
            rd(7'(8'h18 + 8'(16 * i)), "hi_reset", 32'h0);
        end

        // Basic counting on counter 0 from events[3]
        wr(7'h00, 32'h1, '0);
        wr(7'h10, 32'h103, '0);
        pulse(8'h08, 10);
        rd(7'h14, "lo0_count10", 32'd10);
        rd(7'h18, "hi0_count10", 32'h0);
        rd(7'h24, "lo1_idle", 32'h0);
        rd(7'h44, "lo3_idle", 32'h0);
        rd(7'h10, "cfg0_readback", 32'h103);
        rd(7'h0C, "unmapped_0c", 32'h0);
        rd(7'h1C, "unmapped_1c", 32'h0);
        rd(7'h54, "unmapped_slot5", 32'h0);
        rd(7'h15, "misaligned_15", 32'h0);
        @(negedge core_clk);
        addr_bus = 7'h14;
        #1;
        check("fetch_zero_no_sel", data_fetch, 32'h0);

        // Overflow of counter 2 with irq enabled
        wr(7'h38, 32'h0000_FFFF, '0);
        wr(7'h34, 32'hFFFF_FFFE, '0);
        wr(7'h08, 32'h4, '0);
        wr(7'h30, 32'h105, '0);
        @(negedge core_clk);
        events = 8'h20;
        @(posedge core_clk);
        @(posedge core_clk);
        #1;
        check("irq_lags_ovf", 32'(perf_irq), 32'h0);
        @(posedge core_clk);
        #1;
        check("irq_after_ovf", 32'(perf_irq), 32'h1);
        events = '0;
        rd(7'h34, "lo2_wrapped", 32'h1);
        rd(7'h38, "hi2_wrapped", 32'h0);
        rd(7'h04, "ovf_bit2", 32'h4);
        rd(7'h08, "imask_readback", 32'h4);
        wr(7'h04, 32'h4, '0);
        rd(7'h04, "ovf_w1c", 32'h0);
        check("irq_cleared", 32'(perf_irq), 32'h0);

        // Freeze on counter 1 overflow stops counter 0 too
        wr(7'h00, 32'h3, '0);
        wr(7'h20, 32'h106, '0);
        wr(7'h28, 32'h0000_FFFF, '0);
        wr(7'h24, 32'hFFFF_FFFF, '0);
        pulse(8'h48, 5);
        rd(7'h14, "lo0_frozen", 32'd11);
        rd(7'h24, "lo1_wrapped", 32'h0);
        rd(7'h04, "ovf_bit1", 32'h2);
        check("irq_masked", 32'(perf_irq), 32'h0);
        wr(7'h04, 32'h2, '0);
        pulse(8'h08, 4);
        rd(7'h14, "lo0_resumed", 32'd15);

        // HI shadow is tear-free across a carry
        wr(7'h18, 32'h0, '0);
        wr(7'h14, 32'hFFFF_FFFF, '0);
        rd(7'h14, "lo0_pre_carry", 32'hFFFF_FFFF);
        pulse(8'h08, 1);
        rd(7'h18, "hi0_shadow_old", 32'h0);
        rd(7'h14, "lo0_post_carry", 32'h0);
        rd(7'h18, "hi0_shadow_new", 32'h1);

        // W1C colliding with a new overflow keeps the bit
        wr(7'h00, 32'h1, '0);
        wr(7'h18, 32'h0000_FFFF, '0);
        wr(7'h14, 32'hFFFF_FFFF, '0);
        pulse(8'h08, 1);
        rd(7'h04, "ovf_bit0_first", 32'h1);
        wr(7'h18, 32'h0000_FFFF, '0);
        wr(7'h14, 32'hFFFF_FFFF, '0);
        wr(7'h04, 32'h1, 8'h08);
        rd(7'h04, "ovf_w1c_vs_set", 32'h1);
        rd(7'h14, "lo0_rewrapped", 32'h0);

        // HI preload truncation, preload beats increment, clear_all beats increment
        wr(7'h28, 32'hABCD_1234, '0);
        wr(7'h24, 32'h5, '0);
        rd(7'h24, "lo1_preload", 32'h5);
        rd(7'h28, "hi1_truncated", 32'h1234);
        wr(7'h24, 32'h100, 8'h40);
        rd(7'h24, "lo1_preload_wins", 32'h100);
        wr(7'h00, 32'h5, 8'h40);
        rd(7'h24, "lo1_cleared", 32'h0);
        rd(7'h28, "hi1_shadow_cleared", 32'h0);
        rd(7'h04, "ovf_cleared", 32'h0);
        rd(7'h00, "ctrl_clear_reads0", 32'h1);
        rd(7'h20, "cfg1_kept", 32'h106);

        if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
